// File: rtl/mul_share_ctl.sv
// Round-robin sharing controller for one 4x4 serial shift-add multiplier core.
// Two requesters are arbitrated; operands are held across the operation and the product returned with id/error.
module mul_share_ctl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TW      = 8
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_p,
    output logic       rsp_err,
    output logic       mul_start,
    output logic [3:0] mul_a,
    output logic [3:0] mul_b,
    input  logic       mul_ready,
    input  logic [7:0] mul_p,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_FLUSH = 3'd2,
        S_BUSY  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    state_t        state_q;
    logic          last_q;
    logic [TW-1:0] cnt_q;
    logic [3:0]    mul_a_q;
    logic [3:0]    mul_b_q;
    logic          mul_start_q;
    logic          busy_q;
    logic          rsp_valid_q;
    logic          rsp_id_q;
    logic          rsp_err_q;
    logic [7:0]    rsp_p_q;

    logic          gnt_any_s;
    logic          gnt_id_s;
    logic          req0_ready_s;
    logic          req1_ready_s;

    // Round-robin grant: a tie goes to the requester that was not served last.
    always_comb begin
        gnt_any_s    = req0_valid | req1_valid;
        gnt_id_s     = 1'b0;
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id_s = ~last_q;
        end else if (req1_valid) begin
            gnt_id_s = 1'b1;
        end else begin
            gnt_id_s = 1'b0;
        end
        if (state_q == S_IDLE) begin
            req0_ready_s = req0_valid & ~gnt_id_s;
            req1_ready_s = req1_valid &  gnt_id_s;
        end else begin
            req0_ready_s = 1'b0;
            req1_ready_s = 1'b0;
        end
    end

    // Sequencer: accept, pulse start, skip the core's load cycle, wait for ready or time out, hold response.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            mul_a_q     <= 4'd0;
            mul_b_q     <= 4'd0;
            mul_start_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_p_q     <= 8'd0;
        end else begin
            mul_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_any_s) begin
                        mul_a_q     <= gnt_id_s ? req1_a : req0_a;
                        mul_b_q     <= gnt_id_s ? req1_b : req0_b;
                        rsp_id_q    <= gnt_id_s;
                        last_q      <= gnt_id_s;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    state_q <= S_FLUSH;
                end
                S_FLUSH: begin
                    // mul_ready may still be high from the previous product here
                    cnt_q   <= '0;
                    state_q <= S_BUSY;
                end
                S_BUSY: begin
                    if (mul_ready) begin
                        rsp_p_q     <= mul_p;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        rsp_p_q     <= 8'd0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = req0_ready_s;
    assign req1_ready = req1_ready_s;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_p      = rsp_p_q;
    assign rsp_err    = rsp_err_q;
    assign mul_start  = mul_start_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mul_share_ctl.sv
// Self-checking bench for mul_share_ctl with a behavioural multiplier core model.
// Expected products, grant order and latencies come from plain arithmetic and a round-robin model.
module tb_mul_share_ctl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, mul_start, busy;
    logic [7:0] rsp_p, mul_p;
    logic [3:0] mul_a, mul_b;
    logic       mul_ready;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic model_last;

    // core model: 0 nominal, 1 never ready, 2 ready stays high through FLUSH then never again
    int         core_mode  = 0;
    int         core_cnt   = 0;
    logic       core_ready = 1'b0;
    logic [7:0] core_p     = 8'd0;

    mul_share_ctl dut (
        .clock(clock), .resetn(resetn),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .rsp_err(rsp_err), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ready(mul_ready), .mul_p(mul_p), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (mul_start) begin
            core_p     <= 8'(mul_a) * 8'(mul_b);
            core_cnt   <= 5;
            core_ready <= (core_mode == 2);
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1 && core_mode == 0) core_ready <= 1'b1;
            else if (core_mode != 0)             core_ready <= 1'b0;
        end
    end

    assign mul_ready = core_ready;
    assign mul_p     = core_p;

    task automatic run_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                          output int lat, output int start_cnt, output int start_at,
                          output logic stable, output logic [7:0] p, output logic err,
                          output logic rid);
        int acc;
        int k;
        lat = -1; start_cnt = 0; start_at = -1; stable = 1'b1; p = 8'd0; err = 1'b0; rid = 1'b0;
        if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
        #1;
        k = 0;
        while (!(id ? req1_ready : req0_ready) && k < 40) begin
            @(posedge clock); #2; k++;
        end
        if (k >= 40) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(posedge clock); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        model_last = id;
        k = 0;
        while (!rsp_valid && k < 60) begin
            if (mul_start) begin start_cnt++; start_at = cyc - acc; end
            if (mul_a !== a || mul_b !== b) stable = 1'b0;
            @(posedge clock); #1; k++;
        end
        if (!rsp_valid) return;
        lat = cyc - acc; p = rsp_p; err = rsp_err; rid = rsp_id;
        if (mul_a !== a || mul_b !== b) stable = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = 4'd0; req0_b = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
        #2 resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b0)      $display("FAIL rst_busy: got %0h want 0", busy);           else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %0h want 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_p !== 8'd0)     $display("FAIL rst_rsp_p: got %0h want 0", rsp_p);         else n_pass++;
        n_checks++; if (rsp_err !== 1'b0)   $display("FAIL rst_rsp_err: got %0h want 0", rsp_err);     else n_pass++;
        n_checks++; if (rsp_id !== 1'b0)    $display("FAIL rst_rsp_id: got %0h want 0", rsp_id);       else n_pass++;
        n_checks++; if (mul_start !== 1'b0) $display("FAIL rst_mul_start: got %0h want 0", mul_start); else n_pass++;
        n_checks++; if ({mul_a, mul_b} !== 8'd0) $display("FAIL rst_mul_ab: got %0h want 0", {mul_a, mul_b}); else n_pass++;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL rst_ready: got %0b want 00", {req0_ready, req1_ready}); else n_pass++;
        resetn = 1'b1; model_last = 1'b1;
        @(posedge clock); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rst_first_tie: got %0b want 10", {req0_ready, req1_ready}); else n_pass++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clock); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_no_transfer: got busy %0h want 0", busy); else n_pass++;
    endtask

    task automatic test_single;
        int lat, sc, sa; logic st, err, rid; logic [7:0] p;
        run_op(1'b0, 4'd3, 4'd5, lat, sc, sa, st, p, err, rid);
        n_checks++; if (lat !== 8)    $display("FAIL single_latency: got %0d want 8", lat); else n_pass++;
        n_checks++; if (sc !== 1)     $display("FAIL single_start_count: got %0d want 1", sc); else n_pass++;
        n_checks++; if (sa !== 1)     $display("FAIL single_start_cycle: got %0d want 1", sa); else n_pass++;
        n_checks++; if (p !== 8'h0F)  $display("FAIL single_p: got %0h want 0f", p); else n_pass++;
        n_checks++; if (rid !== 1'b0) $display("FAIL single_id: got %0h want 0", rid); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL single_err: got %0h want 0", err); else n_pass++;
    endtask

    task automatic test_max;
        int lat, sc, sa; logic st, err, rid; logic [7:0] p;
        run_op(1'b1, 4'd15, 4'd15, lat, sc, sa, st, p, err, rid);
        n_checks++; if (p !== 8'hE1)  $display("FAIL max_p: got %0h want e1", p); else n_pass++;
        n_checks++; if (rid !== 1'b1) $display("FAIL max_id: got %0h want 1", rid); else n_pass++;
        n_checks++; if (st !== 1'b1)  $display("FAIL max_operand_stable: got %0h want 1", st); else n_pass++;
        n_checks++; if (lat !== 8)    $display("FAIL max_latency: got %0d want 8", lat); else n_pass++;
    endtask

    task automatic test_random;
        int lat, sc, sa; logic st, err, rid; logic [7:0] p;
        logic id; logic [3:0] a, b;
        for (int i = 0; i < 6; i++) begin
            id = 1'($urandom); a = 4'($urandom); b = 4'($urandom);
            run_op(id, a, b, lat, sc, sa, st, p, err, rid);
            n_checks++; if (p !== 8'(a) * 8'(b)) $display("FAIL rand_p: a=%0d b=%0d got %0h want %0h", a, b, p, 8'(a) * 8'(b)); else n_pass++;
            n_checks++; if (rid !== id || err !== 1'b0) $display("FAIL rand_id_err: got %0h/%0h want %0h/0", rid, err, id); else n_pass++;
            n_checks++; if (lat !== 8 || st !== 1'b1) $display("FAIL rand_lat_stable: got %0d/%0h want 8/1", lat, st); else n_pass++;
        end
    endtask

    task automatic test_fairness;
        logic [3:0] a0, b0, a1, b1;
        logic [8:0] exp_q[$];
        logic [8:0] e;
        logic got_id;
        int prev_acc, grants, acc_id;
        a0 = 4'($urandom); b0 = 4'($urandom_range(1, 15));
        a1 = 4'($urandom); b1 = 4'($urandom_range(1, 15));
        if (a1 == a0) a1 = a0 + 4'd1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        prev_acc = -1; grants = 0;
        for (int k = 0; k < 80; k++) begin
            acc_id = -1;
            #1;
            n_checks++; if (req0_ready && req1_ready) $display("FAIL fair_overlap: got ready 11 want at most one"); else n_pass++;
            if (rsp_valid) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL fair_unexpected_rsp: got id %0h p %0h want none", rsp_id, rsp_p);
                else begin
                    e = exp_q.pop_front();
                    if ({rsp_id, rsp_p} !== e || rsp_err !== 1'b0) $display("FAIL fair_rsp: got %0h err %0h want %0h err 0", {rsp_id, rsp_p}, rsp_err, e);
                    else n_pass++;
                end
            end
            if ((req0_ready || req1_ready) && grants < 4) begin
                got_id = req1_ready;
                n_checks++; if (got_id !== ~model_last) $display("FAIL fair_grant_order: got %0h want %0h", got_id, ~model_last); else n_pass++;
                if (prev_acc >= 0) begin
                    n_checks++; if (cyc - prev_acc != 9) $display("FAIL fair_interval: got %0d want 9", cyc - prev_acc); else n_pass++;
                end
                prev_acc = cyc; model_last = got_id; grants++;
                exp_q.push_back(got_id ? {1'b1, 8'(a1) * 8'(b1)} : {1'b0, 8'(a0) * 8'(b0)});
                acc_id = int'(got_id);
            end
            @(posedge clock); #1;
            if (acc_id == 0)      begin a0 = 4'($urandom); b0 = 4'($urandom); req0_a = a0; req0_b = b0; end
            else if (acc_id == 1) begin a1 = 4'($urandom); b1 = 4'($urandom); req1_a = a1; req1_b = b1; end
            if (grants == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            if (grants == 4 && exp_q.size() == 0) break;
        end
        n_checks++; if (grants != 4 || exp_q.size() != 0) $display("FAIL fair_complete: got grants %0d pending %0d want 4/0", grants, exp_q.size()); else n_pass++;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [3:0] a0, b0, a1, b1;
        int k;
        a0 = 4'($urandom_range(1, 15)); b0 = 4'($urandom_range(1, 15));
        a1 = 4'($urandom_range(1, 15)); b1 = 4'($urandom_range(1, 15));
        req0_a = a0; req0_b = b0; req0_valid = 1'b1; rsp_ready = 1'b0;
        #1;
        k = 0;
        while (!req0_ready && k < 40) begin @(posedge clock); #2; k++; end
        @(posedge clock); #1;
        req0_valid = 1'b0; model_last = 1'b0;
        req1_a = a1; req1_b = b1; req1_valid = 1'b1;
        k = 0;
        while (!rsp_valid && k < 40) begin
            #1;
            n_checks++; if (req1_ready !== 1'b0) $display("FAIL bp_ready_while_busy: got %0h want 0", req1_ready); else n_pass++;
            @(posedge clock); #1; k++;
        end
        req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) $display("FAIL bp_hold_valid_busy: got %0h/%0h want 1/1", rsp_valid, busy); else n_pass++;
            n_checks++; if ({rsp_id, rsp_err, rsp_p} !== {2'b00, 8'(a0) * 8'(b0)}) $display("FAIL bp_hold_rsp: got %0h want %0h", {rsp_id, rsp_err, rsp_p}, {2'b00, 8'(a0) * 8'(b0)}); else n_pass++;
            n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL bp_hold_ready: got %0b want 00", {req0_ready, req1_ready}); else n_pass++;
            @(posedge clock); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        #1;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL bp_next_accept: got %0b want 01", {req0_ready, req1_ready}); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_rsp_released: got %0h want 0", rsp_valid); else n_pass++;
        @(posedge clock); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; model_last = 1'b1;
        k = 0;
        while (!rsp_valid && k < 40) begin @(posedge clock); #1; k++; end
        n_checks++; if ({rsp_valid, rsp_id, rsp_p} !== {2'b11, 8'(a1) * 8'(b1)}) $display("FAIL bp_second_rsp: got %0h want %0h", {rsp_valid, rsp_id, rsp_p}, {2'b11, 8'(a1) * 8'(b1)}); else n_pass++;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout;
        int lat, sc, sa; logic st, err, rid; logic [7:0] p;
        logic [3:0] a, b;
        for (int m = 2; m >= 1; m--) begin
            core_mode = m;
            a = 4'($urandom_range(1, 15)); b = 4'($urandom_range(1, 15));
            run_op(1'b0, a, b, lat, sc, sa, st, p, err, rid);
            n_checks++; if (lat !== 18)   $display("FAIL timeout_latency mode %0d: got %0d want 18", m, lat); else n_pass++;
            n_checks++; if (err !== 1'b1) $display("FAIL timeout_err mode %0d: got %0h want 1", m, err); else n_pass++;
            n_checks++; if (p !== 8'd0)   $display("FAIL timeout_p mode %0d: got %0h want 0", m, p); else n_pass++;
            n_checks++; if (sc !== 1)     $display("FAIL timeout_start_count mode %0d: got %0d want 1", m, sc); else n_pass++;
        end
        core_mode = 0;
    endtask

    task automatic test_reset_mid_busy;
        int lat, sc, sa, k, stray; logic st, err, rid; logic [7:0] p;
        req1_a = 4'd9; req1_b = 4'd11; req1_valid = 1'b1;
        #1;
        k = 0;
        while (!req1_ready && k < 40) begin @(posedge clock); #2; k++; end
        @(posedge clock); #1;
        req1_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %0h want 1", busy); else n_pass++;
        resetn = 1'b0;
        #1;
        n_checks++; if ({busy, rsp_valid, rsp_id, rsp_err, mul_start} !== 5'd0) $display("FAIL midrst_flags: got %0b want 00000", {busy, rsp_valid, rsp_id, rsp_err, mul_start}); else n_pass++;
        n_checks++; if ({rsp_p, mul_a, mul_b} !== 16'd0) $display("FAIL midrst_data: got %0h want 0", {rsp_p, mul_a, mul_b}); else n_pass++;
        @(posedge clock); #1;
        resetn = 1'b1; model_last = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (rsp_valid || busy) stray++;
        end
        n_checks++; if (stray != 0) $display("FAIL midrst_leftover: got %0d active cycles want 0", stray); else n_pass++;
        run_op(1'b0, 4'd2, 4'd7, lat, sc, sa, st, p, err, rid);
        n_checks++; if (p !== 8'h0E)  $display("FAIL midrst_p: got %0h want 0e", p); else n_pass++;
        n_checks++; if (lat !== 8 || err !== 1'b0 || rid !== 1'b0) $display("FAIL midrst_op: got lat %0d err %0h id %0h want 8/0/0", lat, err, rid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_max();
        test_random();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
